// File: rtl/cntr_seq_pkg.sv
// cntr_seq_pkg
// Shared types and constants for the cntr_seq command sequencer.
//   op_t    : command opcodes carried on cmd_op
//   state_t : sequencer FSM states
//   is_step : true for the two stepping opcodes
package cntr_seq_pkg;

  localparam logic [1:0] OPC_LOAD = 2'b00;
  localparam logic [1:0] OPC_UP   = 2'b01;
  localparam logic [1:0] OPC_DOWN = 2'b10;
  localparam logic [1:0] OPC_NOP  = 2'b11;

  typedef enum logic [1:0] {
    OP_LOAD = OPC_LOAD,
    OP_UP   = OPC_UP,
    OP_DOWN = OPC_DOWN,
    OP_NOP  = OPC_NOP
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  function automatic logic is_step(input op_t op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/cntr_seq_if.sv
// cntr_seq_if
// Command channel of the sequencer (valid/ready handshake plus payload).
//   cmd_valid : command present            (master -> slave)
//   cmd_ready : sequencer can accept       (slave -> master)
//   cmd_op    : opcode                     (master -> slave)
//   cmd_arg   : load value or step count   (master -> slave)
//   presc     : ce pacing, one per presc+1 (master -> slave)
interface cntr_seq_if #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 8
) ();
  import cntr_seq_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  op_t                cmd_op;
  logic [WIDTH-1:0]   cmd_arg;
  logic [PRESC_W-1:0] presc;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, presc,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, presc,
    output cmd_ready
  );

endinterface

// File: rtl/cntr_seq_presc.sv
// cntr_seq_presc
// Reloadable down-counter that paces the counter-enable strobes.
//   sys_clk    : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   start      : load reload_val into both the count and the reload register
//   reload_val : prescale value presented at command accept
//   clr        : clear the count (abort)
//   run        : count while the sequencer is stepping
//   tick       : count has reached zero while running
module cntr_seq_presc #(
  parameter int PRESC_W = 8
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [PRESC_W-1:0] reload_val,
  input  logic               clr,
  input  logic               run,
  output logic               tick
);

  logic [PRESC_W-1:0] count;
  logic [PRESC_W-1:0] reload_q;

  assign tick = run && (count == '0);

  // The reload value is captured at start so later changes on the presc
  // input cannot disturb a command already in progress.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      reload_q <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (start) begin
      count    <= reload_val;
      reload_q <= reload_val;
    end else if (run) begin
      if (count == '0) count <= reload_q;
      else             count <= count - PRESC_W'(1);
    end
  end

endmodule

// File: rtl/cntr_seq.sv
// cntr_seq
// Command-driven sequencer in front of the binary counter my_cntr.
//   sys_clk    : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   cmd        : command channel (slave side of cntr_seq_if)
//   abort      : cancel the active LOAD or RUN command
//   data       : load value to the counter
//   load       : counter load strobe
//   ce         : counter enable strobe
//   updn       : counter direction, 1 = up
//   busy       : sequencer not idle
//   done       : one-cycle completion pulse
//   steps_left : remaining ce pulses for the active command
module cntr_seq #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 8
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  cntr_seq_if.slave        cmd,
  input  logic             abort,
  output logic [WIDTH-1:0] data,
  output logic             load,
  output logic             ce,
  output logic             updn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] steps_left
);
  import cntr_seq_pkg::*;

  state_t state;
  logic   tick;
  logic   start_run;
  logic   presc_clr;

  // A step command with a nonzero count is the only one that needs pacing.
  assign start_run = cmd.cmd_valid && (state == S_IDLE) &&
                     is_step(cmd.cmd_op) && (cmd.cmd_arg != '0);
  assign presc_clr = abort && (state == S_RUN);

  // Strobes come from registered state; abort is the only input allowed to
  // reach them, so a cancelled command never produces a stray load or ce.
  assign cmd.cmd_ready = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign load          = (state == S_LOAD) && !abort;
  assign ce            = tick && !abort;

  cntr_seq_presc #(.PRESC_W(PRESC_W)) u_presc (
    .sys_clk    (sys_clk),
    .reset_n    (reset_n),
    .start      (start_run),
    .reload_val (cmd.presc),
    .clr        (presc_clr),
    .run        (state == S_RUN),
    .tick       (tick)
  );

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      data       <= '0;
      updn       <= 1'b1;
      steps_left <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            unique case (cmd.cmd_op)
              OP_LOAD: begin
                data  <= cmd.cmd_arg;
                state <= S_LOAD;
              end
              OP_UP, OP_DOWN: begin
                if (cmd.cmd_arg != '0) begin
                  steps_left <= cmd.cmd_arg;
                  updn       <= (cmd.cmd_op == OP_UP);
                  state      <= S_RUN;
                end else begin
                  state <= S_DONE;
                end
              end
              OP_NOP: state <= S_DONE;
            endcase
          end
        end
        S_LOAD: state <= abort ? S_IDLE : S_DONE;
        S_RUN: begin
          if (abort) begin
            steps_left <= '0;
            state      <= S_IDLE;
          end else if (tick) begin
            if (steps_left != '0) steps_left <= steps_left - WIDTH'(1);
            if (steps_left == WIDTH'(1)) state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cntr_seq.md
# cntr_seq

Command-driven sequencer sitting directly upstream of the parameterised binary counter `my_cntr`. It accepts load/step commands over a valid/ready handshake and drives the counter's `data`, `load`, `ce` and `updn` inputs. Count-enable pulses are paced by a programmable prescaler. A one-cycle `done` pulse is reported when each command has finished.

## Interface
- `WIDTH`, 4: counter width; must match the downstream counter.
- `PRESC_W`, 8: prescaler width.

- `sys_clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 2: 00 LOAD, 01 STEP_UP, 10 STEP_DOWN, 11 NOP.
- `cmd_arg` in WIDTH: load value (LOAD) or step count (STEP_*).
- `presc` in PRESC_W: one `ce` every `presc+1` cycles; sampled at command accept.
- `abort` in 1: cancel the active command.
- `data` out WIDTH: load value to the counter.
- `load` out 1: counter load strobe.
- `ce` out 1: counter enable strobe.
- `updn` out 1: direction, 1 = up.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.
- `steps_left` out WIDTH: remaining `ce` pulses for the active command.

## Operation
- **States:** IDLE, LOAD, RUN, DONE.
- **Accept:** `cmd_valid && cmd_ready` at a rising edge. At accept, `cmd_op`, `cmd_arg` and `presc` are latched.
- **IDLE, on accept:**
  - LOAD: `data` <= `cmd_arg`, go to LOAD.
  - STEP_UP / STEP_DOWN with `cmd_arg` != 0: `steps_left` <= `cmd_arg`, tick <= `presc`, `updn` <= (op == STEP_UP), go to RUN.
  - STEP_* with `cmd_arg` == 0, or NOP: go to DONE.
- **LOAD:** `load` = 1 for exactly one cycle, then go to DONE.
- **RUN:**
  - If tick != 0: tick decrements.
  - If tick == 0: `ce` = 1 this cycle, tick <= latched `presc`, `steps_left` decrements.
  - On the cycle where `ce` fires with `steps_left` == 1: go to DONE.
- **DONE:** `done` = 1 for one cycle, then go to IDLE.
- **Abort:**
  - `abort` in LOAD or RUN forces `load`/`ce` to 0 in that cycle.
  - Next state is IDLE with no `done` pulse; `steps_left` is cleared.
  - `abort` in IDLE or DONE is ignored.
- **Simultaneous events:** `abort` together with `cmd_valid` in IDLE accepts the command.
- **Output decoding:** `ce`, `load`, `done`, `busy` and `cmd_ready` are decoded combinationally from registered state only, with no input-to-output paths except `abort` gating `ce`/`load`.
- **Held outputs:** `data` and `updn` hold their last values in IDLE. `updn` is constant throughout RUN.
- **Arithmetic:** `steps_left` and tick are unsigned, and they never wrap; decrement happens only when the value is nonzero.

## Timing
- **Reset values (while `reset_n` low):**
  - state IDLE.
  - `data` = 0, `load` = 0, `ce` = 0, `updn` = 1, `busy` = 0, `done` = 0, `steps_left` = 0, tick = 0.
  - `cmd_ready` = 1 immediately after deassertion.
- **Reset mid-command:** returns to IDLE asynchronously. No further `ce`/`load`, no `done`.
- **Step command:** accept at edge E0, with k steps and prescale p.
  - `ce` is high in cycles E0 + j·(p+1), for j = 1..k (cycle 1 is the cycle after E0).
  - `done` is high in cycle k·(p+1) + 1.
  - `cmd_ready` is high again in cycle k·(p+1) + 2.
- **Load command:** `load` in cycle 1, `done` in cycle 2, ready in cycle 3.
- **Zero-step / NOP:** `done` in cycle 1, ready in cycle 2.
- **Throughput:** minimum spacing between accepts is 2 cycles.

## Structure
- **Package `cntr_seq_pkg`:**
  - `op_t` enum (OP_LOAD, OP_UP, OP_DOWN, OP_NOP).
  - `state_t` enum (S_IDLE, S_LOAD, S_RUN, S_DONE).
  - Op encoding constants.
- **Sub-module `cntr_seq_presc`:** PRESC_W-bit reloadable down-counter with inputs `start`, `reload_val`, `clr`, and output `tick`. It is high when the count is 0 in RUN.
- **Top level:** FSM, command latch and `steps_left` counter.

## Test plan
- **Reset:** assert `reset_n` low mid-RUN (STEP_UP 5, presc 2) -> `ce` stops immediately; `busy` = 0, `steps_left` = 0, `updn` = 1, `cmd_ready` = 1 after release.
- **Load:** LOAD `cmd_arg` = 4'hA -> `data` = 4'hA and `load` = 1 in cycle 1 only; `done` in cycle 2; `cmd_ready` in cycle 3.
- **Step up:** STEP_UP 3, presc 0 -> `ce` in cycles 1, 2, 3 with `updn` = 1; `done` in cycle 4; `steps_left` goes 3 -> 0.
- **Step down with prescale:** STEP_DOWN 2, presc 3 -> `ce` in cycles 4 and 8 only, `updn` = 0; `done` in cycle 9. Changing `presc` mid-run has no effect.
- **Abort:** STEP_UP 15, presc 1, `abort` in cycle 5 -> `ce` low in cycle 5, IDLE in cycle 6, no `done`, `steps_left` = 0.
- **Corner cases:**
  - STEP_UP 0 -> no `ce`, `done` in cycle 1.
  - `cmd_valid` held high while busy -> no second accept until `cmd_ready`.
  - `abort` with `cmd_valid` in IDLE -> command accepted.
